ram_sync_param: RTL and testbench



---
 rtl/ram_pkg.sv | 23 ++
 rtl/ram_sweep_ctrl.sv | 68 ++++++
 rtl/ram_sync_param.sv | 78 +++++++
 tb/tb_ram_sync_param.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised single-port RAM: sweep FSM states and
// pointer sizing helpers.
package ram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_FILL  = 2'd2
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Sweep pointer width, never narrower than one bit.
   function automatic int ptr_w(input int depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

endpackage

// File: rtl/ram_sweep_ctrl.sv
// Clear/fill sweep engine: walks every implemented word once, writing zeros
// (after reset) or all-ones (on set), and flags busy while doing so.
module ram_sweep_ctrl
   import ram_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 16,
   parameter int PTR_W  = ptr_w(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_set,
   output logic              o_sweep_we,
   output logic [PTR_W-1:0]  o_sweep_addr,
   output logic [DATA_W-1:0] o_sweep_data,
   output logic              o_busy
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   state_t           r_state, w_state_nxt;
   logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
   logic             r_busy;

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         ST_IDLE: begin
            if (i_set) begin
               w_state_nxt = ST_FILL;
               w_ptr_nxt   = '0;
            end
         end
         ST_CLEAR, ST_FILL: begin
            // The sweep ends on the last implemented word; the pointer never wraps.
            if (r_ptr == LAST) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = '0;
            end else begin
               w_ptr_nxt = r_ptr + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_CLEAR;
         r_ptr   <= '0;
         r_busy  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
      end
   end

   assign o_sweep_we   = (r_state != ST_IDLE) && !i_reset;
   assign o_sweep_addr = r_ptr;
   assign o_sweep_data = (r_state == ST_FILL) ? {DATA_W{1'b1}} : '0;
   assign o_busy       = r_busy;

endmodule

// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with registered read, valid strobe
// and a hardware clear/fill sweep that locks out user access while busy.
module ram_sync_param
   import ram_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set,
   input  logic              write_enable,
   input  logic              read_enable,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              busy
);

   localparam int PTR_W = ptr_w(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_data_out;
   logic              r_data_valid;

   logic              w_sweep_we;
   logic [PTR_W-1:0]  w_sweep_addr;
   logic [DATA_W-1:0] w_sweep_data;
   logic              w_busy;
   logic              w_user_ok;
   logic              w_in_range;
   logic [PTR_W-1:0]  w_uidx;

   ram_sweep_ctrl #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_sweep (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_set        (set),
      .o_sweep_we   (w_sweep_we),
      .o_sweep_addr (w_sweep_addr),
      .o_sweep_data (w_sweep_data),
      .o_busy       (w_busy)
   );

   // A set request in IDLE swallows any user access in the same cycle.
   assign w_user_ok  = !w_busy && !set && !reset;
   assign w_in_range = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
   assign w_uidx     = addr[PTR_W-1:0];

   always_ff @(posedge clk) begin
      if (w_sweep_we)
         r_mem[w_sweep_addr] <= w_sweep_data;
      else if (w_user_ok && write_enable && w_in_range)
         r_mem[w_uidx] <= data_in;
   end

   // Old contents are sampled here, so a same-address write is read-before-write.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
      end else begin
         r_data_valid <= w_user_ok && read_enable;
         if (w_user_ok && read_enable)
            r_data_out <= w_in_range ? r_mem[w_uidx] : '0;
      end
   end

   assign data_out   = r_data_out;
   assign data_valid = r_data_valid;
   assign busy       = w_busy;

endmodule

// File: tb/tb_ram_sync_param.sv
// Directed bench for ram_sync_param: default 16x4 instance plus a 12-word instance.
module tb_ram_sync_param;

   logic       clk = 1'b0;
   logic       reset = 1'b1, set = 1'b0, write_enable = 1'b0, read_enable = 1'b0;
   logic [3:0] addr = '0, data_in = '0;
   logic [3:0] data_out;
   logic       data_valid, busy;

   logic       reset12 = 1'b1, set12 = 1'b0, we12 = 1'b0, re12 = 1'b0;
   logic [3:0] addr12 = '0, din12 = '0;
   logic [3:0] dout12;
   logic       valid12, busy12;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ram_sync_param dut (
      .clk(clk), .reset(reset), .set(set), .write_enable(write_enable),
      .read_enable(read_enable), .addr(addr), .data_in(data_in),
      .data_out(data_out), .data_valid(data_valid), .busy(busy)
   );

   ram_sync_param #(.DATA_W(4), .ADDR_W(4), .DEPTH(12)) dut12 (
      .clk(clk), .reset(reset12), .set(set12), .write_enable(we12),
      .read_enable(re12), .addr(addr12), .data_in(din12),
      .data_out(dout12), .data_valid(valid12), .busy(busy12)
   );

   typedef struct {
      logic       we;
      logic       re;
      logic [3:0] addr;
      logic [3:0] din;
      logic       exp_v;
      logic [3:0] exp_d;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Counts cycles with busy high; optionally issues a write to addr 5 at cycle wr_at.
   task automatic busy_run(output int n, output int vbad, input int wr_at);
      n = 0;
      vbad = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         if (data_valid !== 1'b0) vbad++;
         write_enable = (n == wr_at);
         addr    = 4'd5;
         data_in = 4'b0011;
         step();
      end
      write_enable = 1'b0;
   endtask

   task automatic read_all(input string nm, input logic [3:0] exp);
      for (int a = 0; a < 16; a++) begin
         read_enable = 1'b1;
         addr = 4'(a);
         step();
         chk($sformatf("%s_v%0d", nm, a), data_valid, 1'b1);
         chk($sformatf("%s_d%0d", nm, a), data_out, exp);
      end
      read_enable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[$];
      int   n, vb;

      vecs = '{
         '{1'b1, 1'b0, 4'd0, 4'b1010, 1'b0, 4'b0000},
         '{1'b1, 1'b0, 4'd1, 4'b0101, 1'b0, 4'b0000},
         '{1'b1, 1'b0, 4'd2, 4'b1111, 1'b0, 4'b0000},
         '{1'b1, 1'b0, 4'd3, 4'b0001, 1'b0, 4'b0000},
         '{1'b0, 1'b1, 4'd0, 4'b0000, 1'b1, 4'b1010},
         '{1'b0, 1'b1, 4'd1, 4'b0000, 1'b1, 4'b0101},
         '{1'b0, 1'b1, 4'd2, 4'b0000, 1'b1, 4'b1111},
         '{1'b0, 1'b1, 4'd3, 4'b0000, 1'b1, 4'b0001},
         '{1'b0, 1'b0, 4'd3, 4'b0000, 1'b0, 4'b0001},
         '{1'b1, 1'b1, 4'd2, 4'b0011, 1'b1, 4'b1111},
         '{1'b0, 1'b1, 4'd2, 4'b0000, 1'b1, 4'b0011},
         '{1'b0, 1'b1, 4'd15, 4'b0000, 1'b1, 4'b0000}
      };

      // Reset held two cycles, then the clear sweep.
      step();
      step();
      chk("rst_busy", busy, 1'b1);
      chk("rst_valid", data_valid, 1'b0);
      chk("rst_dout", data_out, 4'b0000);
      reset = 1'b0;
      busy_run(n, vb, 0);
      chk("clear_cycles", n, 16);
      chk("clear_valid_low", vb, 0);
      read_all("clr", 4'b0000);
      step();
      chk("valid_drop", data_valid, 1'b0);

      // Table: writes, back-to-back reads, read-before-write.
      foreach (vecs[i]) begin
         write_enable = vecs[i].we;
         read_enable  = vecs[i].re;
         addr         = vecs[i].addr;
         data_in      = vecs[i].din;
         step();
         chk($sformatf("vec%0d_valid", i), data_valid, vecs[i].exp_v);
         chk($sformatf("vec%0d_dout", i), data_out, vecs[i].exp_d);
      end
      write_enable = 1'b0;
      read_enable  = 1'b0;

      // Fill: set wins over a same-cycle read/write; write during busy ignored.
      set = 1'b1;
      write_enable = 1'b1;
      read_enable = 1'b1;
      addr = 4'd0;
      data_in = 4'b0011;
      step();
      set = 1'b0;
      write_enable = 1'b0;
      read_enable = 1'b0;
      chk("fill_set_drop_valid", data_valid, 1'b0);
      chk("fill_busy", busy, 1'b1);
      set = 1'b1;
      step();
      set = 1'b0;
      chk("fill_set_while_busy", busy, 1'b1);
      busy_run(n, vb, 10);
      chk("fill_cycles", n, 15);
      chk("fill_valid_low", vb, 0);
      step();
      chk("fill_no_requeue", busy, 1'b0);
      read_all("fill", 4'b1111);
      step();

      // Reset in the middle of a fill sweep.
      set = 1'b1;
      step();
      set = 1'b0;
      repeat (8) step();
      chk("midfill_busy", busy, 1'b1);
      reset = 1'b1;
      step();
      chk("midrst_dout", data_out, 4'b0000);
      chk("midrst_valid", data_valid, 1'b0);
      chk("midrst_busy", busy, 1'b1);
      step();
      reset = 1'b0;
      busy_run(n, vb, 0);
      chk("midrst_cycles", n, 16);
      read_all("midrst", 4'b0000);

      // 12-word instance.
      step();
      reset12 = 1'b0;
      n = 0;
      while (busy12 === 1'b1 && n < 40) begin
         n++;
         step();
      end
      chk("d12_cycles", n, 12);
      re12 = 1'b1; addr12 = 4'd11;
      step();
      chk("d12_rd11_v", valid12, 1'b1);
      chk("d12_rd11_d", dout12, 4'b0000);
      re12 = 1'b0; we12 = 1'b1; din12 = 4'b0110;
      step();
      we12 = 1'b0; re12 = 1'b1;
      step();
      chk("d12_wr11_d", dout12, 4'b0110);
      re12 = 1'b0; we12 = 1'b1; addr12 = 4'd13; din12 = 4'b1001;
      step();
      we12 = 1'b0; re12 = 1'b1;
      step();
      chk("d12_rd13_v", valid12, 1'b1);
      chk("d12_rd13_d", dout12, 4'b0000);
      addr12 = 4'd1;
      step();
      chk("d12_rd1_d", dout12, 4'b0000);
      addr12 = 4'd11;
      step();
      chk("d12_rd11b_d", dout12, 4'b0110);
      re12 = 1'b0;
      step();
      chk("d12_valid_drop", valid12, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
